// File: rtl/pio_pkg.sv
// Shared definitions for the LED output PIO: register map and width helper.
package pio_pkg;

   localparam logic [1:0] ADDR_DATA  = 2'd0;
   localparam logic [1:0] ADDR_BLINK = 2'd1;
   localparam logic [1:0] ADDR_SET   = 2'd2;
   localparam logic [1:0] ADDR_CLR   = 2'd3;

   // Bits needed to hold the values 0..value-1 (minimum 1)
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/led_out_pio_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
interface led_out_pio_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_blink_prescaler.sv
// Free-running blink prescaler: counts BLINK_DIV cycles per half-period and
// toggles phase on each wrap. A clear restarts both counter and phase.
module pio_blink_prescaler
   import pio_pkg::*;
#(
   parameter int BLINK_DIV = 25000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic phase
);

   localparam int             CW   = clog2(BLINK_DIV);
   localparam logic [CW-1:0]  LAST = CW'(BLINK_DIV - 1);

   logic [CW-1:0] count;

   // Counter and phase; clear wins over the wrap/toggle on the same edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         phase <= 1'b0;
      end else if (clear) begin
         count <= '0;
         phase <= 1'b0;
      end else if (count == LAST) begin
         count <= '0;
         phase <= ~phase;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/led_out_pio.sv
// LED output PIO: data register with atomic set/clear, per-bit blink mask,
// registered read-back. out_port depends on registers only.
module led_out_pio
   import pio_pkg::*;
#(
   parameter int          DATA_WIDTH  = 32,
   parameter logic [31:0] RESET_VALUE = 32'd0,
   parameter int          BLINK_DIV   = 25000000
) (
   input  logic                  clk,
   input  logic                  reset,
   led_out_pio_if.slave          bus,
   output logic [DATA_WIDTH-1:0] out_port
);

   localparam logic [DATA_WIDTH-1:0] DATA_RST = RESET_VALUE[DATA_WIDTH-1:0];

   logic                  we;
   logic                  blink_clr;
   logic                  blink_phase;
   logic [DATA_WIDTH-1:0] wd;
   logic [DATA_WIDTH-1:0] data;
   logic [DATA_WIDTH-1:0] blink_mask;
   logic [31:0]           rd_next;
   logic [31:0]           readdata_q;
   logic                  unused_wd;

   assign we        = bus.chipselect & ~bus.write_n;
   assign wd        = bus.writedata[DATA_WIDTH-1:0];
   assign blink_clr = we && (bus.address == ADDR_BLINK);
   // Upper writedata bits are intentionally discarded for narrow ports
   assign unused_wd = ^bus.writedata;

   pio_blink_prescaler #(.BLINK_DIV(BLINK_DIV)) u_presc (
      .clk   (clk),
      .reset (reset),
      .clear (blink_clr),
      .phase (blink_phase)
   );

   // Register file: one register updated per write, set/clear are read-modify-write on data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data       <= DATA_RST;
         blink_mask <= '0;
      end else if (we) begin
         case (bus.address)
            ADDR_DATA:  data       <= wd;
            ADDR_BLINK: blink_mask <= wd;
            ADDR_SET:   data       <= data | wd;
            ADDR_CLR:   data       <= data & ~wd;
            default:    ;
         endcase
      end
   end

   // Read mux; write-only registers read as zero
   always_comb begin
      rd_next = '0;
      case (bus.address)
         ADDR_DATA:  rd_next[DATA_WIDTH-1:0] = data;
         ADDR_BLINK: rd_next[DATA_WIDTH-1:0] = blink_mask;
         default:    rd_next = '0;
      endcase
   end

   // Read data captured every cycle, so a coincident write returns the old value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) readdata_q <= '0;
      else       readdata_q <= rd_next;
   end

   assign bus.readdata = readdata_q;
   assign out_port     = data ^ (blink_mask & {DATA_WIDTH{blink_phase}});

endmodule

// File: tb/tb_led_out_pio.sv
// Directed bench for led_out_pio (DATA_WIDTH=8, RESET_VALUE=A5, BLINK_DIV=4).
module tb_led_out_pio;

   logic       clk;
   logic       clk_en;
   logic       reset;
   logic [7:0] out_port;
   int         n_cmp;
   int         n_bad;

   led_out_pio_if bus ();

   led_out_pio #(
      .DATA_WIDTH  (8),
      .RESET_VALUE (32'h0000_00A5),
      .BLINK_DIV   (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .out_port (out_port)
   );

   always #5 if (clk_en) clk = ~clk;

   typedef struct {
      logic [1:0]  addr;
      logic        cs;
      logic        wn;
      logic [31:0] wd;
      logic [7:0]  exp_out;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic bus_idle();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = 32'h0;
   endtask

   // One-cycle write; returns at the negedge just after the write edge
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.writedata  = d;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.address = a;
      @(negedge clk);
      d = bus.readdata;
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  exp8;
      n_cmp  = 0;
      n_bad  = 0;
      clk    = 1'b0;
      clk_en = 1'b0;
      reset  = 1'b0;
      bus.address = 2'd0;
      bus_idle();

      //                 addr  cs    wn    wdata          out    readdata (pre-write)
      vecs[0]  = '{2'd0, 1'b1, 1'b0, 32'h0000_0000, 8'h00, 32'h0000_00A5};
      vecs[1]  = '{2'd2, 1'b1, 1'b0, 32'h0000_0011, 8'h11, 32'h0000_0000};
      vecs[2]  = '{2'd3, 1'b1, 1'b0, 32'h0000_0001, 8'h10, 32'h0000_0000};
      vecs[3]  = '{2'd0, 1'b0, 1'b1, 32'h0000_0000, 8'h10, 32'h0000_0010};
      vecs[4]  = '{2'd0, 1'b0, 1'b0, 32'h0000_0055, 8'h10, 32'h0000_0010};
      vecs[5]  = '{2'd0, 1'b1, 1'b1, 32'h0000_0055, 8'h10, 32'h0000_0010};
      vecs[6]  = '{2'd0, 1'b1, 1'b0, 32'hFFFF_FF3C, 8'h3C, 32'h0000_0010};
      vecs[7]  = '{2'd0, 1'b0, 1'b1, 32'h0000_0000, 8'h3C, 32'h0000_003C};
      vecs[8]  = '{2'd1, 1'b0, 1'b1, 32'h0000_0000, 8'h3C, 32'h0000_0000};
      vecs[9]  = '{2'd2, 1'b0, 1'b0, 32'h0000_00FF, 8'h3C, 32'h0000_0000};
      vecs[10] = '{2'd3, 1'b1, 1'b1, 32'h0000_00FF, 8'h3C, 32'h0000_0000};

      // Reset with no clock running
      #1 reset = 1'b1;
      #1;
      chk("reset out_port", {24'h0, out_port}, 32'h0000_00A5);
      chk("reset readdata", bus.readdata, 32'h0);
      clk_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      read_reg(2'd0, rd);
      chk("read data after reset", rd, 32'h0000_00A5);

      // Table: set/clear, qualifiers, writedata truncation, read-before-write
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         bus.address    = vecs[i].addr;
         bus.chipselect = vecs[i].cs;
         bus.write_n    = vecs[i].wn;
         bus.writedata  = vecs[i].wd;
         @(negedge clk);
         bus_idle();
         chk($sformatf("vec%0d out_port", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
         chk($sformatf("vec%0d readdata", i), bus.readdata, vecs[i].exp_rd);
      end

      // Blink: 4 cycles per phase starting at phase 0 from the mask write
      bus_write(2'd0, 32'h0F);
      bus_write(2'd1, 32'hFF);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         exp8 = ((k / 4) % 2 == 1) ? 8'hF0 : 8'h0F;
         chk($sformatf("blink cyc%0d", k), {24'h0, out_port}, {24'h0, exp8});
      end
      // Two more edges puts us mid phase 1, then drop the mask
      @(negedge clk);
      @(negedge clk);
      chk("blink mid phase1", {24'h0, out_port}, 32'h0000_00F0);
      bus_write(2'd1, 32'h00);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("mask off cyc%0d", k), {24'h0, out_port}, 32'h0000_000F);
      end

      // Blink priority: rewrite mask while prescaler sits at its last count
      bus_write(2'd1, 32'h01);
      chk("prio after first mask", {24'h0, out_port}, 32'h0000_000F);
      @(negedge clk);
      @(negedge clk);
      bus_write(2'd1, 32'h01);
      chk("prio no toggle", {24'h0, out_port}, 32'h0000_000F);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("prio count restarted", {24'h0, out_port}, 32'h0000_000F);
      @(negedge clk);
      chk("prio first toggle", {24'h0, out_port}, 32'h0000_000E);
      read_reg(2'd1, rd);
      chk("read blink_mask", rd, 32'h0000_0001);
      chk("phase1 before reset", {24'h0, out_port}, 32'h0000_000E);

      // Asynchronous reset pulse between clock edges
      #2 reset = 1'b1;
      #1;
      chk("async reset out_port", {24'h0, out_port}, 32'h0000_00A5);
      chk("async reset readdata", bus.readdata, 32'h0);
      #1 reset = 1'b0;
      read_reg(2'd1, rd);
      chk("mask cleared by reset", rd, 32'h0);
      read_reg(2'd0, rd);
      chk("data after async reset", rd, 32'h0000_00A5);
      chk("out_port after async reset", {24'h0, out_port}, 32'h0000_00A5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_out_pio.md
Name: led_out_pio

Overview:
- Avalon-MM slave output port: the write-side counterpart of the existing read-only input PIO.
- Drives a DATA_WIDTH-bit out_port to the LEDs from a software-written data register.
- Adds atomic per-bit set and clear registers, plus a per-bit hardware blink mode driven by a free-running prescaler.
- Sits in the internal pin interface alongside the input PIO, on the same clock domain.

Parameters:
- DATA_WIDTH, 32, width of out_port and of the data and mask registers (1..32).
- RESET_VALUE, 0, value loaded into the data register on reset.
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- address  input  2  word address of the register
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe, qualified by chipselect
- writedata  input  32  write data; bits above DATA_WIDTH are ignored
- readdata  output  32  registered read data
- out_port  output  DATA_WIDTH  LED drive

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. All state is cleared on assertion of reset, with no clock required.
- Reset values:
  - data = RESET_VALUE
  - blink_mask = 0
  - prescaler = 0
  - blink_phase = 0
  - readdata = 0
  - out_port therefore = RESET_VALUE
- Write strobe: we = chipselect & ~write_n. At most one register is written per cycle.
- Register map (word address):
  - 0 DATA: R/W. A write loads data <= writedata[DATA_WIDTH-1:0].
  - 1 BLINK_MASK: R/W. A write loads blink_mask; the same edge clears the prescaler and blink_phase to 0.
  - 2 OUTSET: W-only. A write does data <= data | writedata. Reads return 0.
  - 3 OUTCLEAR: W-only. A write does data <= data & ~writedata. Reads return 0.
- Read path:
  - Every cycle, readdata <= zero-extended mux(address), independent of chipselect.
  - Latency is 1 clk, with no wait states.
  - The value captured is the pre-write register value when a read and a write to the same address coincide.
- Prescaler:
  - Counts 0..BLINK_DIV-1 and wraps to 0.
  - On the cycle the count equals BLINK_DIV-1, the next edge sets prescaler to 0 and toggles blink_phase.
  - Width is clog2(BLINK_DIV).
  - A BLINK_MASK write takes priority over the wrap/toggle on the same edge.
- Output:
  - out_port = data ^ (blink_mask & {DATA_WIDTH{blink_phase}}).
  - Driven from registers only, with no combinational path from bus inputs.
  - A masked bit shows its data value in phase 0 and the inverse in phase 1.
  - Writes to data take effect on out_port on the edge after the write cycle.
- Boundary conditions:
  - A write with chipselect low, or with write_n high, changes nothing.
  - Writedata bits >= DATA_WIDTH are discarded.
  - blink_mask = 0 makes out_port equal data exactly, while the prescaler keeps running.
  - Reset asserted mid-blink forces the reset values immediately. Counting restarts from 0 on the first edge after deassertion.

Decomposition:
- Shared package pio_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_BLINK=1, ADDR_SET=2, ADDR_CLR=3
  - function clog2 for the prescaler width
- One natural sub-module, pio_blink_prescaler, which contains:
  - the counter and phase flip-flop
  - inputs clk, reset, clear
  - output phase
- The register file and read mux stay in led_out_pio.

Test Plan (BLINK_DIV=4, DATA_WIDTH=8, RESET_VALUE=8'hA5):
1. Reset: assert reset with no clock running -> out_port=8'hA5, readdata=0. Deassert, then read addr0 -> readdata=32'h000000A5 one cycle later.
2. Set/clear:
   - Write addr0=8'h00, then addr2=8'h11, then addr3=8'h01.
   - Required out_port sequence: 00, 11, 10.
   - Read addr2 -> 0.
3. Blink:
   - Write addr0=8'h0F, then addr1=8'hFF.
   - out_port=0F for 4 cycles, then F0 for 4 cycles, repeating.
   - Write addr1=0 mid-phase -> out_port=0F on the next edge and stays there.
4. Qualifiers:
   - Write addr0=8'h55 with chipselect=0 -> no change.
   - Write with write_n=1 -> no change.
   - Write writedata=32'hFFFF_FF3C -> data=8'h3C.
5. Blink priority: write addr1=8'h01 on the cycle the prescaler is at 3 -> prescaler=0 and phase=0, with no toggle that edge.
6. Reset mid-operation: while blinking with phase=1, pulse reset asynchronously -> out_port=8'hA5 immediately and blink_mask=0.
